// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : interrupt_controller_pkg
//  Purpose : Shared types and helpers for the interrupt controller:
//            controller state encoding and vector width calculation.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package interrupt_controller_pkg;

    // Controller life cycle of a single (non-nesting) interrupt.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Width needed to encode a source index; never narrower than one bit.
    function automatic int vec_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_priority_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : irq_priority_arbiter
//  Purpose : Combinational arbiter. Picks the first set request bit, searching
//            upward (with wrap-around) from start_idx.
//  Ports   : req         in   NUM_SRC  request vector (already masked)
//            start_idx   in   VEC_W    index that has highest priority
//            grant_valid out  1        at least one request is set
//            grant_idx   out  VEC_W    index of the winning request
//  Rev     : 1.0  initial release
// ============================================================================
module irq_priority_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [VEC_W-1:0]   start_idx,
    output logic               grant_valid,
    output logic [VEC_W-1:0]   grant_idx
);

    always_comb begin
        logic [VEC_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            // Modulo keeps the candidate inside 0..NUM_SRC-1 even when
            // NUM_SRC is not a power of two.
            cand = VEC_W'((int'(start_idx) + off) % NUM_SRC);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : interrupt_controller
//  Purpose : Multiplexes NUM_SRC peripheral interrupt requests onto one CPU
//            interrupt line. Non-nesting: one interrupt in flight at a time.
//            The grant is latched when CPU_IRQ rises and the CPU's IACK/IEND
//            pulses are relayed only to that granted source.
//  Ports   : CLK        in   1        system clock, rising edge
//            RESET_N    in   1        asynchronous active-low reset
//            SRC_IRQ    in   NUM_SRC  per-source level request
//            SRC_MASK   in   NUM_SRC  1 = source ignored by arbitration
//            SRC_IACK   out  NUM_SRC  one-cycle ack pulse to granted source
//            SRC_IEND   out  NUM_SRC  one-cycle end pulse to granted source
//            CPU_IRQ    out  1        interrupt request to CPU (level)
//            CPU_VECTOR out  VEC_W    index of the granted source
//            CPU_IACK   in   1        CPU acknowledge pulse
//            CPU_IEND   in   1        CPU end-of-service pulse
//            IN_SERVICE out  1        high from accepted IACK until SRC_IEND
//  Rev     : 1.0  initial release
// ============================================================================
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int ROUND_ROBIN = 0,
    parameter int VEC_W       = vec_width(NUM_SRC)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] SRC_IRQ,
    input  logic [NUM_SRC-1:0] SRC_MASK,
    output logic [NUM_SRC-1:0] SRC_IACK,
    output logic [NUM_SRC-1:0] SRC_IEND,
    output logic               CPU_IRQ,
    output logic [VEC_W-1:0]   CPU_VECTOR,
    input  logic               CPU_IACK,
    input  logic               CPU_IEND,
    output logic               IN_SERVICE
);

    localparam logic [NUM_SRC-1:0] ONE_HOT_0 = NUM_SRC'(1);
    localparam logic [VEC_W-1:0]   LAST_IDX  = VEC_W'(NUM_SRC - 1);

    state_t             state,      state_nxt;
    logic [VEC_W-1:0]   vec,        vec_nxt;
    logic               irq,        irq_nxt;
    logic [NUM_SRC-1:0] iack,       iack_nxt;
    logic [NUM_SRC-1:0] iend,       iend_nxt;
    logic               in_svc,     in_svc_nxt;
    // Holds the index where the next round-robin search begins, i.e.
    // (last grant + 1) mod NUM_SRC. Resetting it to 0 makes the very first
    // search start at source 0.
    logic [VEC_W-1:0]   rr_start,   rr_start_nxt;

    logic [NUM_SRC-1:0] eligible;
    logic [VEC_W-1:0]   arb_start;
    logic               grant_valid;
    logic [VEC_W-1:0]   grant_idx;

    assign eligible  = SRC_IRQ & ~SRC_MASK;
    assign arb_start = (ROUND_ROBIN != 0) ? rr_start : '0;

    irq_priority_arbiter #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_arbiter (
        .req         (eligible),
        .start_idx   (arb_start),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state and next-output logic. Pulse outputs default to zero so
    // they can only ever be high for the single cycle after a transition.
    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        irq_nxt      = irq;
        iack_nxt     = '0;
        iend_nxt     = '0;
        in_svc_nxt   = in_svc;
        rr_start_nxt = rr_start;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = PENDING;
                    vec_nxt   = grant_idx;
                    irq_nxt   = 1'b1;
                end
            end
            PENDING: begin
                // IEND has no meaning before the CPU has acknowledged;
                // when both arrive together only IACK is honoured.
                if (CPU_IACK) begin
                    state_nxt  = SERVICE;
                    irq_nxt    = 1'b0;
                    iack_nxt   = ONE_HOT_0 << vec;
                    in_svc_nxt = 1'b1;
                end
            end
            SERVICE: begin
                if (CPU_IEND) begin
                    state_nxt    = IDLE;
                    iend_nxt     = ONE_HOT_0 << vec;
                    in_svc_nxt   = 1'b0;
                    rr_start_nxt = (vec == LAST_IDX) ? '0 : vec + VEC_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                irq_nxt    = 1'b0;
                in_svc_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            vec      <= '0;
            irq      <= 1'b0;
            iack     <= '0;
            iend     <= '0;
            in_svc   <= 1'b0;
            rr_start <= '0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            irq      <= irq_nxt;
            iack     <= iack_nxt;
            iend     <= iend_nxt;
            in_svc   <= in_svc_nxt;
            rr_start <= rr_start_nxt;
        end
    end

    assign SRC_IACK   = iack;
    assign SRC_IEND   = iend;
    assign CPU_IRQ    = irq;
    assign CPU_VECTOR = vec;
    assign IN_SERVICE = in_svc;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_interrupt_controller
//  Purpose : Directed self-checking bench. One fixed-priority instance and
//            one round-robin instance, both NUM_SRC=4, 40 ns clock.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // fixed-priority instance
    logic [3:0] irq = '0, mask = '0;
    logic       c_iack = 1'b0, c_iend = 1'b0;
    logic [3:0] s_iack, s_iend;
    logic       c_irq, in_svc;
    logic [1:0] vec;

    // round-robin instance
    logic [3:0] r_irq = '0, r_mask = '0;
    logic       r_c_iack = 1'b0, r_c_iend = 1'b0;
    logic [3:0] r_s_iack, r_s_iend;
    logic       r_c_irq, r_in_svc;
    logic [1:0] r_vec;

    int errors = 0;
    int checks = 0;

    always #20 clk = ~clk;

    interrupt_controller #(.NUM_SRC(4), .ROUND_ROBIN(0), .VEC_W(2)) u_fix (
        .CLK(clk), .RESET_N(rst_n), .SRC_IRQ(irq), .SRC_MASK(mask),
        .SRC_IACK(s_iack), .SRC_IEND(s_iend), .CPU_IRQ(c_irq),
        .CPU_VECTOR(vec), .CPU_IACK(c_iack), .CPU_IEND(c_iend),
        .IN_SERVICE(in_svc)
    );

    interrupt_controller #(.NUM_SRC(4), .ROUND_ROBIN(1), .VEC_W(2)) u_rr (
        .CLK(clk), .RESET_N(rst_n), .SRC_IRQ(r_irq), .SRC_MASK(r_mask),
        .SRC_IACK(r_s_iack), .SRC_IEND(r_s_iend), .CPU_IRQ(r_c_irq),
        .CPU_VECTOR(r_vec), .CPU_IACK(r_c_iack), .CPU_IEND(r_c_iend),
        .IN_SERVICE(r_in_svc)
    );

    // Advance one clock; inputs and samples are taken 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares the whole fixed-instance output bundle:
    // {CPU_IRQ, CPU_VECTOR, SRC_IACK, SRC_IEND, IN_SERVICE}
    task automatic expect_fix(input string tag, input logic e_irq,
                              input logic [1:0] e_vec, input logic [3:0] e_iack,
                              input logic [3:0] e_iend, input logic e_svc);
        logic [11:0] obs, exp;
        obs = {c_irq, vec, s_iack, s_iend, in_svc};
        exp = {e_irq, e_vec, e_iack, e_iend, e_svc};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed irq/vec/iack/iend/svc=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_rr(input string tag, input logic e_irq,
                             input logic [1:0] e_vec, input logic [3:0] e_iack,
                             input logic [3:0] e_iend, input logic e_svc);
        logic [11:0] obs, exp;
        obs = {r_c_irq, r_vec, r_s_iack, r_s_iend, r_in_svc};
        exp = {e_irq, e_vec, e_iack, e_iend, e_svc};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed irq/vec/iack/iend/svc=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- 1: reset and quiet idle ----------------
        rst_n = 1'b0;
        tick(); tick();
        expect_fix("reset_fix", 0, 2'd0, 4'b0, 4'b0, 0);
        expect_rr ("reset_rr",  0, 2'd0, 4'b0, 4'b0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            expect_fix("idle_quiet", 0, 2'd0, 4'b0, 4'b0, 0);
        end

        // ---------------- 2: single request full cycle ----------------
        irq = 4'b0100;
        tick();
        expect_fix("t2_pending", 1, 2'd2, 4'b0, 4'b0, 0);
        c_iack = 1'b1;
        tick();
        expect_fix("t2_iack", 0, 2'd2, 4'b0100, 4'b0, 1);
        c_iack = 1'b0; irq = 4'b0000;
        tick();
        expect_fix("t2_iack_one_cycle", 0, 2'd2, 4'b0, 4'b0, 1);
        c_iend = 1'b1;
        tick();
        expect_fix("t2_iend", 0, 2'd2, 4'b0, 4'b0100, 0);
        c_iend = 1'b0;
        tick();
        expect_fix("t2_iend_one_cycle", 0, 2'd2, 4'b0, 4'b0, 0);

        // ---------------- 3a: fixed priority ----------------
        irq = 4'b1010;
        tick();
        expect_fix("t3_fixed_lowest", 1, 2'd1, 4'b0, 4'b0, 0);
        c_iack = 1'b1;
        tick();
        expect_fix("t3_fixed_iack", 0, 2'd1, 4'b0010, 4'b0, 1);
        c_iack = 1'b0; irq = 4'b0000;
        c_iend = 1'b1;
        tick();
        expect_fix("t3_fixed_iend", 0, 2'd1, 4'b0, 4'b0010, 0);
        c_iend = 1'b0;
        tick();

        // ---------------- 3b: round robin, all held ----------------
        r_irq = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            logic [1:0] ev;
            logic [3:0] oh;
            ev = 2'(k % 4);
            oh = 4'b0001 << ev;
            expect_rr("t3_rr_vector", 1, ev, 4'b0, 4'b0, 0);
            r_c_iack = 1'b1;
            tick();
            r_c_iack = 1'b0;
            expect_rr("t3_rr_iack", 0, ev, oh, 4'b0, 1);
            r_c_iend = 1'b1;
            tick();
            r_c_iend = 1'b0;
            expect_rr("t3_rr_iend", 0, ev, 4'b0, oh, 0);
            tick();
        end
        r_irq = 4'b0000;

        // ---------------- 4: masking and latched grant ----------------
        mask = 4'b0001; irq = 4'b0001;
        tick(); tick(); tick();
        expect_fix("t4_masked", 0, 2'd1, 4'b0, 4'b0, 0);
        mask = 4'b0000;
        tick();
        expect_fix("t4_unmasked", 1, 2'd0, 4'b0, 4'b0, 0);
        irq = 4'b0010;   // source 0 withdraws, source 1 arrives
        tick();
        expect_fix("t4_latched", 1, 2'd0, 4'b0, 4'b0, 0);
        c_iack = 1'b1;
        tick();
        expect_fix("t4_iack_src0", 0, 2'd0, 4'b0001, 4'b0, 1);
        c_iack = 1'b0; irq = 4'b0000;
        c_iend = 1'b1;
        tick();
        expect_fix("t4_iend_src0", 0, 2'd0, 4'b0, 4'b0001, 0);
        c_iend = 1'b0;
        tick();

        // ---------------- 5: IEND in PENDING, IACK+IEND together ----------------
        irq = 4'b1000;
        tick();
        expect_fix("t5_pending", 1, 2'd3, 4'b0, 4'b0, 0);
        c_iend = 1'b1;
        tick();
        expect_fix("t5_iend_ignored", 1, 2'd3, 4'b0, 4'b0, 0);
        c_iack = 1'b1; irq = 4'b0000;
        tick();
        expect_fix("t5_both_only_iack", 0, 2'd3, 4'b1000, 4'b0, 1);
        c_iend = 1'b0;   // CPU_IACK held a second cycle: no new event
        tick();
        expect_fix("t5_iack_held", 0, 2'd3, 4'b0, 4'b0, 1);
        c_iack = 1'b0;
        c_iend = 1'b1;
        tick();
        expect_fix("t5_iend", 0, 2'd3, 4'b0, 4'b1000, 0);
        tick();          // IEND still high but already back in IDLE
        expect_fix("t5_iend_held", 0, 2'd3, 4'b0, 4'b0, 0);
        c_iend = 1'b0;

        // ---------------- 6: reset during SERVICE ----------------
        irq = 4'b0001;
        tick();
        c_iack = 1'b1;
        tick();
        c_iack = 1'b0; irq = 4'b0000;
        expect_fix("t6_in_service", 0, 2'd0, 4'b0001, 4'b0, 1);
        tick();
        #5 rst_n = 1'b0;
        #1;
        expect_fix("t6_async_reset", 0, 2'd0, 4'b0, 4'b0, 0);
        c_iend = 1'b1;
        tick();
        expect_fix("t6_no_iend_in_reset", 0, 2'd0, 4'b0, 4'b0, 0);
        rst_n = 1'b1;
        tick();
        c_iend = 1'b0;
        expect_fix("t6_idle_after_reset", 0, 2'd0, 4'b0, 4'b0, 0);
        irq = 4'b0100;
        tick();
        expect_fix("t6_rerequest", 1, 2'd2, 4'b0, 4'b0, 0);
        c_iack = 1'b1;
        tick();
        c_iack = 1'b0; irq = 4'b0000;
        expect_fix("t6_iack", 0, 2'd2, 4'b0100, 4'b0, 1);
        c_iend = 1'b1;
        tick();
        c_iend = 1'b0;
        expect_fix("t6_iend", 0, 2'd2, 4'b0, 4'b0100, 0);
        tick();
        expect_fix("t6_final_idle", 0, 2'd2, 4'b0, 4'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
